param_alu: RTL and testbench

PARAM_ALU -- requirements
Module: param_alu

---
 rtl/param_alu.sv | 132 +++++++++++++
 tb/tb_param_alu.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/param_alu.sv
// Multi-cycle ALU: single-cycle ADD/SUB, iterative shift-add MUL and restoring DIV.
// Result registers update only on the edge that raises Done and hold until the next completion.
module param_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       ALUOP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic [3:0]       Flags,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned   CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_t;

  state_t           state, state_nxt;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q, acc_hi, acc_lo;
  logic [CW-1:0]    cnt;
  logic             accept, fast, finish;

  logic [WIDTH-1:0] b_eff, res_lo, res_hi, div_diff;
  logic [WIDTH:0]   add_sum, mul_sum, div_shift;
  logic             div_ge, ovf, cry, dz;

  always_comb begin
    accept = Start && (state != CALC);
    fast   = (op_q == OP_ADD) || (op_q == OP_SUB) || ((op_q == OP_DIV) && (b_q == '0));
    finish = (state == CALC) && (fast || (cnt == LAST));
  end

  // One iteration step for each of the two long operations.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_diff  = div_shift[WIDTH-1:0] - b_q;
  end

  always_comb begin
    b_eff   = (op_q == OP_SUB) ? ~b_q : b_q;
    add_sum = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op_q == OP_SUB)};
    res_lo  = '0;
    res_hi  = '0;
    ovf     = 1'b0;
    cry     = 1'b0;
    dz      = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        res_lo = add_sum[WIDTH-1:0];
        cry    = add_sum[WIDTH];
        ovf    = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_MUL: begin
        res_lo = acc_lo;
        res_hi = acc_hi;
        ovf    = |acc_hi;
      end
      default: begin
        if (b_q == '0) begin
          res_lo = '1;
          res_hi = a_q;
          dz     = 1'b1;
        end else begin
          res_lo = acc_lo;
          res_hi = acc_hi;
        end
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (finish) state_nxt = DONE;
      DONE:    state_nxt = accept ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
    Busy = (state == CALC);
    Done = (state == DONE);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
      Result   <= '0;
      ResultHi <= '0;
      Flags    <= '0;
    end else if (accept) begin
      op_q   <= op_t'(ALUOP);
      a_q    <= A;
      b_q    <= B;
      acc_hi <= '0;
      acc_lo <= A;
      cnt    <= '0;
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      if (finish) begin
        Result   <= res_lo;
        ResultHi <= res_hi;
        Flags    <= {dz, ovf, cry, (res_lo == '0)};
      end else if (op_q == OP_MUL) begin
        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
      end else begin
        // Restoring division: remainder in acc_hi, quotient bits shift into acc_lo.
        acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
      end
    end
  end

endmodule

// File: tb/tb_param_alu.sv
// Directed vector bench for param_alu at WIDTH=16, with hand-written busy-ignore,
// mid-operation reset and back-to-back sequences.
module tb_param_alu;

  logic        Clock;
  logic        Reset_n;
  logic        Start;
  logic [1:0]  ALUOP;
  logic [15:0] A, B;
  logic [15:0] Result, ResultHi;
  logic [3:0]  Flags;
  logic        Busy, Done;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  param_alu #(.WIDTH(16)) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .ALUOP    (ALUOP),
    .A        (A),
    .B        (B),
    .Result   (Result),
    .ResultHi (ResultHi),
    .Flags    (Flags),
    .Busy     (Busy),
    .Done     (Done)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a, b, r, hi;
    logic [3:0]  fl;
    int unsigned lat;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit first, input int idx);
    int unsigned n;
    bit          busy_ok;
    if (!first) @(negedge Clock);
    Start = 1'b1; ALUOP = v.op; A = v.a; B = v.b;
    @(posedge Clock); #1;
    Start = 1'b0; ALUOP = ~v.op; A = ~v.a; B = v.b ^ 16'h00FF;
    busy_ok = Busy;
    n = 0;
    do begin
      @(posedge Clock); #1;
      n++;
      if (Done && Busy)   busy_ok = 1'b0;
      if (!Done && !Busy) busy_ok = 1'b0;
    end while (!Done && n < 40);
    check($sformatf("v%0d_latency", idx), n, v.lat);
    check($sformatf("v%0d_busy", idx), {31'd0, busy_ok}, 32'd1);
    check($sformatf("v%0d_result", idx), {16'd0, Result}, {16'd0, v.r});
    check($sformatf("v%0d_resulthi", idx), {16'd0, ResultHi}, {16'd0, v.hi});
    check($sformatf("v%0d_flags", idx), {28'd0, Flags}, {28'd0, v.fl});
    @(posedge Clock); #1;
    check($sformatf("v%0d_hold", idx), {15'd0, Done, Result}, {16'd0, v.r});
  endtask

  initial begin
    int unsigned n;
    int unsigned done_cnt;

    vecs[0]  = '{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b0011, 1};
    vecs[1]  = '{2'b01, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0110, 1};
    vecs[2]  = '{2'b10, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 4'b0100, 17};
    vecs[3]  = '{2'b11, 16'd1000, 16'd7,    16'h008E, 16'h0006, 4'b0000, 17};
    vecs[4]  = '{2'b11, 16'h00AB, 16'h0000, 16'hFFFF, 16'h00AB, 4'b1000, 1};
    vecs[5]  = '{2'b00, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b0100, 1};
    vecs[6]  = '{2'b01, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 4'b0011, 1};
    vecs[7]  = '{2'b01, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 4'b0000, 1};
    vecs[8]  = '{2'b10, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0100, 17};
    vecs[9]  = '{2'b10, 16'h00FF, 16'h0002, 16'h01FE, 16'h0000, 4'b0000, 17};
    vecs[10] = '{2'b10, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 4'b0001, 17};
    vecs[11] = '{2'b11, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 4'b0000, 17};
    vecs[12] = '{2'b11, 16'h0003, 16'h0007, 16'h0000, 16'h0003, 4'b0001, 17};
    vecs[13] = '{2'b11, 16'hFFFF, 16'h00FF, 16'h0101, 16'h0000, 4'b0000, 17};
    vecs[14] = '{2'b00, 16'h1234, 16'h4321, 16'h5555, 16'h0000, 4'b0000, 1};

    Reset_n = 1'b1; Start = 1'b0; ALUOP = 2'b00; A = '0; B = '0;
    #1 Reset_n = 1'b0;
    #2;
    check("reset_state", {13'd0, Busy, Done, Flags, Result, ResultHi},
          {13'd0, 1'b0, 1'b0, 4'b0000, 16'h0000, 16'h0000});

    // Start is raised together with reset release so the first edge accepts it.
    @(negedge Clock);
    Reset_n = 1'b1;
    run_vec(vecs[0], 1'b1, 0);
    for (int i = 1; i < NV; i++) run_vec(vecs[i], 1'b0, i);

    // Start pulsed while a MUL is busy must be ignored.
    @(negedge Clock);
    Start = 1'b1; ALUOP = 2'b10; A = 16'h1234; B = 16'h0100;
    @(posedge Clock); #1;
    Start = 1'b0;
    n = 0;
    do begin
      @(posedge Clock); #1;
      n++;
      Start = (n == 4);
      ALUOP = 2'b00; A = 16'h0001; B = 16'h0001;
    end while (!Done && n < 40);
    Start = 1'b0;
    check("ign_latency", n, 17);
    check("ign_result", {Result, ResultHi}, {16'h3400, 16'h0012});
    check("ign_flags", {28'd0, Flags}, {28'd0, 4'b0100});

    // Reset in the middle of a MUL: outputs clear at once and no Done follows.
    @(negedge Clock);
    Start = 1'b1; ALUOP = 2'b10; A = 16'h00FF; B = 16'h00FF;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (7) @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b0;
    #1;
    check("midreset_clear", {13'd0, Busy, Done, Flags, Result, ResultHi},
          {13'd0, 1'b0, 1'b0, 4'b0000, 16'h0000, 16'h0000});
    @(negedge Clock);
    Reset_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge Clock); #1;
      if (Done || Busy) done_cnt++;
    end
    check("midreset_no_done", done_cnt, 0);

    // Back-to-back: Start held through the ADD's Done cycle accepts the SUB.
    @(negedge Clock);
    Start = 1'b1; ALUOP = 2'b00; A = 16'h0001; B = 16'h0002;
    @(posedge Clock); #1;
    ALUOP = 2'b01; A = 16'h0005; B = 16'h0003;
    @(posedge Clock); #1;
    check("b2b_add_done", {15'd0, Done, Result}, {15'd0, 1'b1, 16'h0003});
    @(posedge Clock); #1;
    Start = 1'b0;
    check("b2b_sub_busy", {30'd0, Done, Busy}, {30'd0, 1'b0, 1'b1});
    @(posedge Clock); #1;
    check("b2b_sub_done", {11'd0, Done, Flags, Result}, {11'd0, 1'b1, 4'b0010, 16'h0002});
    @(posedge Clock); #1;
    check("b2b_done_single", {31'd0, Done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
